// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES GF(2^8) helpers, ShiftRows permutations and round-stage FSM type (inverse helpers under MIX_INV_EN)
package aes_pkg;

  localparam int         AES_BLOCK_W = 128;
  localparam logic [7:0] AES_POLY    = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1; the carry out of bit 7 folds back as 0x1B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

`ifdef MIX_INV_EN
  function automatic logic [7:0] gf_mul4(input logic [7:0] b);
    return xtime(xtime(b));
  endfunction

  function automatic logic [7:0] gf_mul8(input logic [7:0] b);
    return xtime(xtime(xtime(b)));
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    return gf_mul8(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mulb(input logic [7:0] b);
    return gf_mul8(b) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_muld(input logic [7:0] b);
    return gf_mul8(b) ^ gf_mul4(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mule(input logic [7:0] b);
    return gf_mul8(b) ^ gf_mul4(b) ^ xtime(b);
  endfunction
`endif

  // Row r of the state moves left by r columns: new (c,r) takes old (c+r mod 4, r).
  function automatic logic [0:AES_BLOCK_W-1] shift_rows(input logic [0:AES_BLOCK_W-1] s);
    logic [0:AES_BLOCK_W-1] t;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[32*c + 8*r +: 8] = s[32*((c + r) % 4) + 8*r +: 8];
      end
    end
    return t;
  endfunction

`ifdef MIX_INV_EN
  // Row r of the state moves right by r columns: new (c,r) takes old (c-r mod 4, r).
  function automatic logic [0:AES_BLOCK_W-1] inv_shift_rows(input logic [0:AES_BLOCK_W-1] s);
    logic [0:AES_BLOCK_W-1] t;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[32*c + 8*r +: 8] = s[32*((c + 4 - r) % 4) + 8*r +: 8];
      end
    end
    return t;
  endfunction
`endif

endpackage

// File: rtl/mix_column.sv
// rtl/mix_column.sv - combinational single-column MixColumns, InvMixColumns added when MIX_INV_EN is defined
module mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
`ifdef MIX_INV_EN
  input  logic        decrypt,
`endif
  output logic [31:0] col_out
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] e0, e1, e2, e3;

  // Row 0 of the column sits in the top byte.
  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  // Forward circulant matrix {02,03,01,01}.
  always_comb begin
    e0 = gf_mul2(a0) ^ gf_mul3(a1) ^ a2          ^ a3;
    e1 = a0          ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3;
    e2 = a0          ^ a1          ^ gf_mul2(a2) ^ gf_mul3(a3);
    e3 = gf_mul3(a0) ^ a1          ^ a2          ^ gf_mul2(a3);
  end

`ifdef MIX_INV_EN
  logic [7:0] d0, d1, d2, d3;

  // Inverse circulant matrix {0e,0b,0d,09}.
  always_comb begin
    d0 = gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3);
    d1 = gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3);
    d2 = gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3);
    d3 = gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3);
  end

  assign col_out = decrypt ? {d0, d1, d2, d3} : {e0, e1, e2, e3};
`else
  assign col_out = {e0, e1, e2, e3};
`endif

endmodule

// File: rtl/shift_mix_serial.sv
// rtl/shift_mix_serial.sv - AES ShiftRows then column-serial MixColumns round stage (decrypt path under MIX_INV_EN)
module shift_mix_serial
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [0:AES_BLOCK_W-1] in_state,
  input  logic                   last_round,
`ifdef MIX_INV_EN
  input  logic                   decrypt,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [0:AES_BLOCK_W-1] out_state
);

  state_t                 state;
  logic [1:0]             col;
  logic [0:AES_BLOCK_W-1] work;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic [31:0]            col_cur;
  logic [31:0]            col_mixed;
  logic [0:AES_BLOCK_W-1] shifted;

  // Column col of the work register, row 0 in the top byte.
  assign col_cur = work[{col, 5'b00000} +: 32];

`ifdef MIX_INV_EN
  logic dec_q;

  assign shifted = decrypt ? inv_shift_rows(in_state) : shift_rows(in_state);

  mix_column u_mix_column (
    .col_in  (col_cur),
    .decrypt (dec_q),
    .col_out (col_mixed)
  );
`else
  assign shifted = shift_rows(in_state);

  mix_column u_mix_column (
    .col_in  (col_cur),
    .col_out (col_mixed)
  );
`endif

  // Sequence IDLE -> (BUSY x4) -> DONE; handshake flags are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      col         <= 2'd0;
      work        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef MIX_INV_EN
      dec_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work       <= shifted;
            col        <= 2'd0;
            in_ready_q <= 1'b0;
`ifdef MIX_INV_EN
            dec_q      <= decrypt;
`endif
            // The final round skips the column pass; the decision is carried by the state itself.
            if (last_round) begin
              state       <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state       <= BUSY;
            end
          end
        end
        BUSY: begin
          work[{col, 5'b00000} +: 32] <= col_mixed;
          col                         <= col + 2'd1;
          if (col == 2'd3) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // in_ready returns one cycle after the output handshake, never in the same cycle.
          if (out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          col         <= 2'd0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = work;

endmodule

// File: tb/tb_shift_mix_serial.sv
// tb/tb_shift_mix_serial.sv - self-checking bench for shift_mix_serial (MIX_INV_EN cases compiled in when defined)
module tb_shift_mix_serial;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] in_state;
  logic         last_round;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] out_state;
`ifdef MIX_INV_EN
  logic         decrypt;
`endif

  int nvec = 0;
  int nmis = 0;

  shift_mix_serial dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_state   (in_state),
    .last_round (last_round),
`ifdef MIX_INV_EN
    .decrypt    (decrypt),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_state  (out_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Generic shift-and-add GF(2^8) product reduced by 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  // Reference round: byte permutation by index arithmetic then a circulant matrix product.
  function automatic logic [0:127] model(input logic [0:127] s, input logic last, input logic dec);
    logic [7:0] b[16];
    logic [7:0] t[16];
    logic [7:0] coef[4];
    logic [7:0] acc;
    logic [0:127] r;
    for (int k = 0; k < 16; k++) b[k] = s[8*k +: 8];
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        t[4*c + rw] = dec ? b[4*((c + 4 - rw) % 4) + rw] : b[4*((c + rw) % 4) + rw];
    if (dec) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (last) begin
          acc = t[4*c + i];
        end else begin
          acc = 8'h00;
          for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j - i + 4) % 4], t[4*c + j]);
        end
        r[32*c + 8*i +: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [0:127] act, input logic [0:127] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Present one block, measure edges from accept to out_valid, then consume the result.
  task automatic run_block(input logic [0:127] blk, input logic last,
                           output logic [0:127] res, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    in_state   = blk;
    last_round = last;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    in_state   = {$urandom, $urandom, $urandom, $urandom};
    last_round = ~last;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    res = out_state;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [0:127] blk;
    logic         last;
    logic [0:127] exp;
    int           lat;
  } vec_t;

  vec_t         tbl[7];
  logic [0:127] res;
  logic [0:127] held;
  logic [0:127] blk;
  logic [0:127] b2b_in[4];
  logic [0:127] b2b_exp[4];
  int           lat;
  int           acc_cyc[4];
  int           nacc;
  int           nout;
  logic         acc;
  logic         hs;
  logic         lr;
  logic         dv;

  initial begin
    tbl[0] = '{{4{32'hdb135345}}, 1'b0, {4{32'h8e4da1bc}}, 5};
    tbl[1] = '{{4{32'hf20a225c}}, 1'b0, {4{32'h9fdc589d}}, 5};
    tbl[2] = '{{4{32'hc6c6c6c6}}, 1'b0, {4{32'hc6c6c6c6}}, 5};
    tbl[3] = '{{4{32'h01010101}}, 1'b0, {4{32'h01010101}}, 5};
    tbl[4] = '{{4{32'hd4d4d4d5}}, 1'b0, {4{32'hd5d5d7d6}}, 5};
    tbl[5] = '{{4{32'h2d26314c}}, 1'b0, {4{32'h4d7ebdf8}}, 5};
    tbl[6] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b1,
               128'h00050a0f04090e03080d02070c01060b, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_state = '0; last_round = 1'b0;
`ifdef MIX_INV_EN
    decrypt = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", {127'd0, in_ready}, 128'd1);
    check("reset_out_valid", {127'd0, out_valid}, 128'd0);
    check("reset_out_state", out_state, 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fixed vectors from known MixColumns columns and the last-round permutation.
    for (int i = 0; i < 7; i++) begin
      run_block(tbl[i].blk, tbl[i].last, res, lat);
      check($sformatf("tbl%0d_state", i), res, tbl[i].exp);
      check($sformatf("tbl%0d_latency", i), 128'(lat), 128'(tbl[i].lat));
    end

    // Asynchronous reset two edges into the column pass.
    in_state = tbl[1].blk; last_round = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midbusy_rst_in_ready", {127'd0, in_ready}, 128'd1);
    check("midbusy_rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("midbusy_rst_out_state", out_state, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_block(tbl[0].blk, 1'b0, res, lat);
    check("after_rst_state", res, tbl[0].exp);
    check("after_rst_latency", 128'(lat), 128'd5);

    // Backpressure in DONE with a competing in_valid.
    in_state = tbl[4].blk; last_round = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int g = 0; g < 20 && !out_valid; g++) begin
      @(posedge clk); #1;
    end
    held = out_state;
    check("bp_result", held, tbl[4].exp);
    in_valid = 1'b1; in_state = tbl[2].blk;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_state_stable", out_state, held);
      check("bp_in_ready_low", {127'd0, in_ready}, 128'd0);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_in_ready", {127'd0, in_ready}, 128'd1);
    check("bp_release_out_valid", {127'd0, out_valid}, 128'd0);

`ifdef MIX_INV_EN
    decrypt = 1'b1;
    run_block({4{32'h8e4da1bc}}, 1'b0, res, lat);
    check("inv_column", res, {4{32'hdb135345}});
    blk = {$urandom, $urandom, $urandom, $urandom};
    decrypt = 1'b0;
    run_block(blk, 1'b1, res, lat);
    decrypt = 1'b1;
    run_block(res, 1'b1, res, lat);
    check("roundtrip_shift", res, blk);
    decrypt = 1'b0;
    run_block({4{32'h2d26314c}}, 1'b0, res, lat);
    decrypt = 1'b1;
    run_block(res, 1'b0, res, lat);
    check("roundtrip_mix", res, {4{32'h2d26314c}});
    decrypt = 1'b0;
`endif

    // Random blocks against the reference model.
    for (int i = 0; i < 30; i++) begin
      blk = {$urandom, $urandom, $urandom, $urandom};
      lr  = ($urandom_range(0, 3) == 0);
      dv  = 1'b0;
`ifdef MIX_INV_EN
      dv  = $urandom_range(0, 1) == 1;
      decrypt = dv;
`endif
      run_block(blk, lr, res, lat);
      check($sformatf("rand%0d_state", i), res, model(blk, lr, dv));
      check($sformatf("rand%0d_latency", i), 128'(lat), lr ? 128'd1 : 128'd5);
    end
`ifdef MIX_INV_EN
    decrypt = 1'b0;
`endif

    // Back-to-back stream with in_valid and out_ready held high.
    for (int i = 0; i < 4; i++) begin
      b2b_in[i]  = {$urandom, $urandom, $urandom, $urandom};
      b2b_exp[i] = model(b2b_in[i], 1'b0, 1'b0);
    end
    nacc = 0; nout = 0;
    last_round = 1'b0; in_state = b2b_in[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 80 && nout < 4; cyc++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (hs) begin
        check($sformatf("b2b_out%0d", nout), out_state, b2b_exp[nout]);
        nout++;
      end
      if (acc && nacc < 4) begin
        acc_cyc[nacc] = cyc;
        nacc++;
      end
      @(posedge clk); #1;
      if (acc) begin
        if (nacc < 4) in_state = b2b_in[nacc];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_accepts", 128'(nacc), 128'd4);
    check("b2b_outputs", 128'(nout), 128'd4);
    for (int i = 1; i < nacc; i++)
      check($sformatf("b2b_interval%0d", i), 128'(acc_cyc[i] - acc_cyc[i-1]), 128'd6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
